// File: rtl/s2pc_receiver.sv
// Serial-to-parallel receiver: assembles WIDTH qualified serial bits into a word
// and offers it on p_out with a valid/ack handshake and a sticky overrun flag.
//
// Handshake: a word is offered while p_valid=1; the consumer takes it by raising
// p_ack, and the transfer happens on the posedge where p_valid=1 and p_ack=1.
// p_ack while p_valid=0 has no effect. On the serial side, every posedge with
// s_valid=1 (and s_clr=0) consumes exactly one bit of s_in; s_in is ignored otherwise.
module s2pc_receiver #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_in,
   input  logic             s_valid,
   input  logic             s_clr,
   output logic [WIDTH-1:0] p_out,
   output logic             p_valid,
   input  logic             p_ack,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] word_next;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             word_done;

   logic [WIDTH-1:0] p_out_d;
   logic             p_valid_d;
   logic             overrun_d;

   // The shift register is cleared between words, so after WIDTH insertions the
   // first bit has travelled to word[0] (LSB first) or word[WIDTH-1] (MSB first).
   if (LSB_FIRST) begin : g_lsb_first
      assign word_next = {s_in, shift_q[WIDTH-1:1]};
   end else begin : g_msb_first
      assign word_next = {shift_q[WIDTH-2:0], s_in};
   end

   // ------------------------------------------------------------------
   // Word assembly FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;

      if (s_clr) begin
         // Abort beats a coincident s_valid: that bit is never captured.
         state_d = IDLE;
         shift_d = '0;
         cnt_d   = '0;
      end else if (s_valid) begin
         case (state_q)
            IDLE: begin
               shift_d = word_next;
               cnt_d   = ONE_CNT;
               state_d = SHIFT;
            end
            SHIFT: begin
               if (cnt_q == LAST_CNT) begin
                  word_done = 1'b1;
                  shift_d   = '0;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end else begin
                  shift_d = word_next;
                  cnt_d   = cnt_q + ONE_CNT;
               end
            end
            default: begin
               state_d = IDLE;
               shift_d = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output word register and handshake
   // ------------------------------------------------------------------
   always_comb begin
      p_out_d   = p_out;
      p_valid_d = p_valid;
      overrun_d = overrun;

      if (word_done) begin
         // A word being acknowledged this edge frees the slot for the new one.
         if (!p_valid || p_ack) begin
            p_out_d   = word_next;
            p_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (p_valid && p_ack) begin
         p_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_out   <= '0;
         p_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         p_out   <= p_out_d;
         p_valid <= p_valid_d;
         overrun <= overrun_d;
      end
   end

   // busy is the FSM state made visible.
   assign busy    = (state_q == SHIFT);
   assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_s2pc_receiver.sv
// Bench for s2pc_receiver: an LSB-first and an MSB-first instance share one bit
// stream; a bit-list reference model feeds per-instance expected-word queues.
module tb_s2pc_receiver;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         s_in;
   logic         s_valid;
   logic         s_clr;
   logic         p_ack;

   logic [W-1:0] p_out_l, p_out_m;
   logic         p_valid_l, p_valid_m;
   logic         busy_l, busy_m;
   logic         overrun_l, overrun_m;
   logic [2:0]   bit_cnt_l, bit_cnt_m;

   s2pc_receiver #(.WIDTH(W), .LSB_FIRST(1'b1), .CNT_W(3)) u_lsb (
      .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .s_clr(s_clr),
      .p_out(p_out_l), .p_valid(p_valid_l), .p_ack(p_ack), .busy(busy_l),
      .overrun(overrun_l), .bit_cnt(bit_cnt_l)
   );

   s2pc_receiver #(.WIDTH(W), .LSB_FIRST(1'b0), .CNT_W(3)) u_msb (
      .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .s_clr(s_clr),
      .p_out(p_out_m), .p_valid(p_valid_m), .p_ack(p_ack), .busy(busy_m),
      .overrun(overrun_m), .bit_cnt(bit_cnt_m)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int           n_checks = 0;
   int           n_pass   = 0;
   bit           mon_en   = 1'b0;
   logic [W-1:0] exp_l[$];
   logic [W-1:0] exp_m[$];

   // Reference model: the bits of the word in progress, in arrival order.
   logic         bits_q[$];
   bit           pend;
   bit           ovr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic fail_note(input string name);
      n_checks++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic logic [W-1:0] pack(input bit msb_first);
      logic [W-1:0] w;
      w = '0;
      for (int k = 0; k < W; k++)
         if (bits_q[k]) w = w | (msb_first ? (W'(1) << (W - 1 - k)) : (W'(1) << k));
      return w;
   endfunction

   task automatic model_reset();
      bits_q.delete();
      pend = 1'b0;
      ovr  = 1'b0;
      exp_l.delete();
      exp_m.delete();
   endtask

   // Effect of one posedge with the given inputs.
   task automatic model_step(input logic v, input logic b, input logic clr, input logic ack);
      bit done;
      logic [W-1:0] wl, wm;
      done = 1'b0;
      wl = '0;
      wm = '0;
      if (clr) begin
         bits_q.delete();
      end else if (v) begin
         bits_q.push_back(b);
         if (bits_q.size() == W) begin
            done = 1'b1;
            wl = pack(1'b0);
            wm = pack(1'b1);
            bits_q.delete();
         end
      end
      if (done) begin
         if (!pend || ack) begin
            exp_l.push_back(wl);
            exp_m.push_back(wm);
            pend = 1'b1;
         end else begin
            ovr = 1'b1;
         end
      end else if (pend && ack) begin
         pend = 1'b0;
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         check("busy_l",    busy_l,    bits_q.size() != 0);
         check("busy_m",    busy_m,    bits_q.size() != 0);
         check("bit_cnt_l", bit_cnt_l, bits_q.size());
         check("bit_cnt_m", bit_cnt_m, bits_q.size());
         check("p_valid_l", p_valid_l, pend);
         check("p_valid_m", p_valid_m, pend);
         check("overrun_l", overrun_l, ovr);
         check("overrun_m", overrun_m, ovr);
         if (p_valid_l && p_ack) begin
            if (exp_l.size() == 0) fail_note("word_l unexpected");
            else check("word_l", p_out_l, exp_l.pop_front());
         end
         if (p_valid_m && p_ack) begin
            if (exp_m.size() == 0) fail_note("word_m unexpected");
            else check("word_m", p_out_m, exp_m.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a posedge; applies inputs for the next posedge.
   task automatic cycle(input logic v, input logic b, input logic clr, input logic ack);
      s_valid = v;
      s_in    = v ? b : 1'bz;
      s_clr   = clr;
      p_ack   = ack;
      @(posedge clk);
      model_step(v, b, clr, ack);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic ack_last);
      for (int k = 0; k < W; k++) cycle(1'b1, w[k], 1'b0, (k == W - 1) ? ack_last : 1'b0);
   endtask

   task automatic ack_cycle();
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Reset pulse between edges; outputs must clear before the next posedge.
   task automatic do_reset(input string tag);
      s_valid = 1'b0;
      s_in    = 1'bz;
      s_clr   = 1'b0;
      p_ack   = 1'b0;
      rst     = 1'b1;
      #1;
      check({tag, "_p_out_l"},   p_out_l,   0);
      check({tag, "_p_out_m"},   p_out_m,   0);
      check({tag, "_p_valid_l"}, p_valid_l, 0);
      check({tag, "_overrun_l"}, overrun_l, 0);
      check({tag, "_busy_l"},    busy_l,    0);
      check({tag, "_bit_cnt_l"}, bit_cnt_l, 0);
      check({tag, "_busy_m"},    busy_m,    0);
      model_reset();
      #1;
      rst = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      fail_note("watchdog timeout");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "bench timed out");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst     = 1'b0;
      s_valid = 1'b0;
      s_in    = 1'b0;
      s_clr   = 1'b0;
      p_ack   = 1'b0;
      model_reset();
      #1;
      rst = 1'b1;
      #1;
      check("rst_p_out_l",   p_out_l,   0);
      check("rst_p_valid_l", p_valid_l, 0);
      check("rst_overrun_l", overrun_l, 0);
      check("rst_busy_l",    busy_l,    0);
      check("rst_bit_cnt_l", bit_cnt_l, 0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      // Loopback of 8'hA5, word visible right after the edge taking bit 8.
      send_word(8'hA5, 1'b0);
      check("a5_p_valid_l", p_valid_l, 1);
      check("a5_p_out_l",   p_out_l,   8'hA5);
      check("a5_p_out_m",   p_out_m,   8'hA5);
      check("a5_overrun_l", overrun_l, 0);
      ack_cycle();
      check("a5_acked_valid", p_valid_l, 0);
      check("a5_acked_hold",  p_out_l,   8'hA5);

      // Gaps after bits 2 and 5 pause the count without aborting.
      for (int k = 0; k < W; k++) begin
         logic [W-1:0] g;
         g = 8'h3C;
         cycle(1'b1, g[k], 1'b0, 1'b0);
         if (k == 2 || k == 5) begin
            for (int j = 0; j < 3; j++) begin
               cycle(1'b0, 1'b0, 1'b0, 1'b0);
               check("gap_bit_cnt", bit_cnt_l, k + 1);
               check("gap_busy",    busy_l,    1);
            end
         end
      end
      check("gap_p_out_l", p_out_l, 8'h3C);
      check("gap_p_out_m", p_out_m, 8'h3C);
      ack_cycle();

      // Overrun: second word dropped while the first is unacknowledged.
      send_word(8'h11, 1'b0);
      send_word(8'h22, 1'b0);
      check("ovr_p_out_l",   p_out_l,   8'h11);
      check("ovr_p_out_m",   p_out_m,   8'h88);
      check("ovr_overrun_l", overrun_l, 1);
      ack_cycle();
      check("ovr_acked_valid",  p_valid_l, 0);
      check("ovr_sticky",       overrun_l, 1);
      do_reset("rst1");

      // Ack on the completing edge makes room for the new word.
      send_word(8'h11, 1'b0);
      send_word(8'h22, 1'b1);
      check("sim_p_out_l",   p_out_l,   8'h22);
      check("sim_p_out_m",   p_out_m,   8'h44);
      check("sim_p_valid_l", p_valid_l, 1);
      check("sim_overrun_l", overrun_l, 0);
      ack_cycle();

      // Abort after 4 bits, s_clr winning over a coincident s_valid.
      for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("abort_pre_cnt", bit_cnt_l, 4);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("abort_bit_cnt", bit_cnt_l, 0);
      check("abort_busy",    busy_l,    0);
      send_word(8'hF0, 1'b0);
      check("abort_p_out_l", p_out_l, 8'hF0);
      check("abort_p_out_m", p_out_m, 8'h0F);
      ack_cycle();

      // Reset mid-word, then MSB-first ordering.
      for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("mid_busy",    busy_l,    1);
      check("mid_bit_cnt", bit_cnt_l, 5);
      do_reset("rst2");
      send_word(8'h81, 1'b0);
      check("msb_81_m", p_out_m, 8'h81);
      check("msb_81_l", p_out_l, 8'h81);
      ack_cycle();
      send_word(8'h03, 1'b0);
      check("msb_c0_m", p_out_m, 8'hC0);
      check("msb_c0_l", p_out_l, 8'h03);
      ack_cycle();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 799) == 0) begin
            do_reset("rnd_rst");
         end else begin
            cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0);
         end
      end

      // Drain any pending word.
      for (int n = 0; n < 4 && pend; n++) ack_cycle();
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      mon_en = 1'b0;
      check("drain_exp_l_empty", exp_l.size(), 0);
      check("drain_exp_m_empty", exp_m.size(), 0);
      check("drain_p_valid_l",   p_valid_l,    0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/s2pc_receiver.md
Name: s2pc_receiver

Overview:
- Serial-to-parallel receiver; sits directly downstream of the P2SC datapath and consumes its `sout` / `out_en` pair.
- Collects WIDTH qualified serial bits into a word and presents it on a parallel output with a valid/ack handshake.
- Flags overrun when a new word completes before the previous one is acknowledged.
- Gives the team a loopback path: P2SC to s2pc_receiver returns the original byte.

Parameters:
- WIDTH, 8, bits per word; must be ≥2.
- LSB_FIRST, 1, 1: first received bit lands in p_out[0]; 0: first received bit lands in p_out[WIDTH-1].
- CNT_W, 3, counter width; must be ≥ clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- s_in  input  1  serial data; connects to upstream `sout`; may be z/x while s_valid=0.
- s_valid  input  1  bit qualifier; connects to upstream `out_en`; one bit is consumed per posedge while high.
- s_clr  input  1  synchronous frame abort; discards the partial word.
- p_out  output  WIDTH  last completed word.
- p_valid  output  1  p_out holds an unacknowledged word.
- p_ack  input  1  consumer accepts p_out; only meaningful while p_valid=1.
- busy  output  1  a partial word is in progress (state SHIFT).
- overrun  output  1  sticky; a completed word was dropped.
- bit_cnt  output  CNT_W  bits collected in the current word.

Behaviour:
- Reset (async, rst=1): state=IDLE, shift_reg=0, bit_cnt=0, p_out=0, p_valid=0, overrun=0, busy=0. Outputs take these values immediately, without waiting for a clock edge.
- State IDLE:
  - s_valid=1 at posedge: capture s_in into position 0 of the word (bit order per LSB_FIRST), set bit_cnt=1, go to SHIFT.
  - Otherwise: hold.
- State SHIFT:
  - s_valid=1 at posedge: capture s_in, bit_cnt+1.
  - s_valid=0: hold; gaps of any length are allowed and never abort the word.
  - On the capture that makes WIDTH bits: complete the word, set bit_cnt=0, return to IDLE in the same edge.
- Bit placement:
  - LSB_FIRST=1: the k-th received bit (k=0..WIDTH-1) goes to word[k].
  - LSB_FIRST=0: the k-th received bit goes to word[WIDTH-1-k].
- s_clr=1 at posedge: state=IDLE, bit_cnt=0, partial bits discarded.
  - s_clr has priority over s_valid in the same cycle; that bit is not captured.
  - p_out, p_valid and overrun are unaffected.
- Word completion, at the edge that captures bit WIDTH-1:
  - p_valid=0: p_out loads the completed word and p_valid=1 from the next cycle. Latency is 1 clk after the last bit is sampled.
  - p_valid=1 and p_ack=1 in the same cycle: the new word is loaded and p_valid stays 1; no overrun.
  - p_valid=1 and p_ack=0: the new word is dropped, p_out is unchanged and overrun is set to 1 (sticky until rst).
- Handshake:
  - p_ack=1 while p_valid=1 with no completion that cycle: p_valid=0 at the next edge; p_out holds its value.
  - p_ack while p_valid=0 is ignored.
- busy = (state==SHIFT). bit_cnt is a registered output.
- Back-to-back words: s_valid held high continuously yields one word every WIDTH clks; the first bit of the next word is captured in the edge after completion (IDLE→SHIFT).
- s_in is never sampled while s_valid=0, so a tri-stated upstream bus does not corrupt state.
- rst mid-word: partial word lost and all outputs return to reset values immediately.

Test Plan:
- Loopback LSB_FIRST=1: upstream loads 8'hA5 and drives addr 0..7 with out_en=1 for 8 clks → p_valid rises 1 clk after the 8th bit, p_out=8'hA5, overrun=0.
- Gapped input: send 8'h3C bits with s_valid low for 3 clks after bits 2 and 5 → busy stays 1 throughout, bit_cnt pauses at each gap, p_out=8'h3C.
- Overrun: receive 8'h11 with no ack, then 8'h22 → p_out stays 8'h11, overrun=1; ack → p_valid=0, overrun still 1.
- Simultaneous ack/completion: 8'h11 pending, assert p_ack on the edge completing 8'h22 → p_out=8'h22, p_valid=1, overrun=0.
- Abort: 4 bits in, assert s_clr together with s_valid=1 → bit_cnt=0, state IDLE, busy=0; next 8 bits 8'hF0 → p_out=8'hF0.
- Async reset mid-word plus MSB-first: rst pulse between edges after 5 bits → outputs 0 before the next posedge; with LSB_FIRST=0, bit sequence 1,0,0,0,0,0,0,1 → p_out=8'h81, and sequence 1,1,0,0,0,0,0,0 → p_out=8'hC0.
